// File: rtl/umi_sim_pkg.sv
// umi_sim_pkg: types, constants and host-bridge entry points shared by the
// UMI simulation endpoints (rx and tx).
//
// The host is a self-contained SystemVerilog loopback whose queue (host_q)
// can be filled directly by a testbench. Endpoints call only
// umi_host_init()/umi_host_recv().
package umi_sim_pkg;

  localparam int UMI_PACKET_W = 256;
  localparam int UMI_SEND_OK  = 32'd1;

  typedef logic [UMI_PACKET_W-1:0] umi_packet_t;

  // Result of one receive poll.
  typedef struct packed {
    logic        ok;
    umi_packet_t pkt;
  } umi_rx_t;

  // Loopback host: one queue, opened by pi_umi_init with a non-empty uri.
  umi_packet_t host_q[$];
  int          host_id    = 0;
  bit          host_open  = 1'b0;
  int unsigned recv_calls = 0;

  function automatic void pi_umi_init(input int id, input string uri, input int mode);
    host_id   = id;
    host_open = (mode == 1) && (uri.len() != 0);
  endfunction

  function automatic void pi_umi_recv(input int id, output bit [255:0] rbuf,
                                      output int success);
    recv_calls++;
    if (host_open && (id == host_id) && (host_q.size() != 0)) begin
      rbuf    = host_q.pop_front();
      success = UMI_SEND_OK;
    end else begin
      rbuf    = '0;
      success = 0;
    end
  endfunction

  function automatic void pi_umi_send(input int id, input bit [255:0] sbuf,
                                      output int success);
    if (host_open && (id == host_id)) begin
      host_q.push_back(sbuf);
      success = UMI_SEND_OK;
    end else begin
      success = 0;
    end
  endfunction

  function automatic void umi_host_init(input int id, input string uri);
    pi_umi_init(id, uri, 1);
  endfunction

  function automatic umi_rx_t umi_host_recv(input int id);
    bit [UMI_PACKET_W-1:0] rbuf;
    int                    success;
    umi_rx_t               r;
    pi_umi_recv(id, rbuf, success);
    r.ok  = (success == UMI_SEND_OK);
    r.pkt = rbuf;
    return r;
  endfunction

endpackage

// File: rtl/umi_rx_sim_fifo.sv
// umi_rx_sim_fifo: synchronous FIFO with registered head-of-queue outputs.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write din when not full (push to a full FIFO is ignored)
//   pop       : advance the read pointer when not empty (ignored when empty)
//   dout      : registered head entry; holds while not popped
//   valid     : registered, high when the FIFO holds at least one entry
//   count     : entries held ($clog2(DEPTH)+1 bits)
//   full/empty: pointer-derived status
//
// Pointers carry one extra wrap bit and run modulo 2*DEPTH.
module umi_rx_sim_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         push_ok, pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign count = wr_q - rd_q;
  assign dout  = dout_q;
  assign valid = valid_q;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_d  = wr_q + {{AW{1'b0}}, push_ok};
    rd_d  = rd_q + {{AW{1'b0}}, pop_ok};
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = din;
    end
    valid_d = (wr_d != rd_d);
    // Head is read from the post-write array so a push into an empty FIFO
    // appears on dout at the same edge; an emptied FIFO keeps its last value.
    dout_d  = valid_d ? mem_d[rd_d[AW-1:0]] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/umi_rx_sim.sv
// umi_rx_sim: simulation-only UMI receive endpoint. Pulls 256-bit packets from
// the host bridge and presents them on a valid/ready interface through a
// small prefetch FIFO.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (does not reopen the host queue)
//   ready  : sink accepts the head packet this cycle
//   valid  : registered, a packet is presented
//   packet : registered head-of-FIFO packet
//
// Parameters: DEPTH (FIFO entries, power of two >= 2), POLL_INTERVAL (cycles
// between polls, only with UMI_RX_SIM_THROTTLE_EN).
//
// Macro UMI_RX_SIM_THROTTLE_EN: restricts polling to one cycle in every
// POLL_INTERVAL. Undefined: poll on every eligible cycle.
//
// The queue is opened by the testbench calling the task init(uri).
module umi_rx_sim
  import umi_sim_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int POLL_INTERVAL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready,
  output logic                    valid,
  output logic [UMI_PACKET_W-1:0] packet
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int HOST_ID = 0;

  // Set only by init(); reset leaves it alone.
  logic          connected = 1'b0;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          unused_full;
  logic          pop;
  logic          poll_slot;
  logic          poll_en;
  umi_rx_t       host_rx_q;

  task automatic init(input string uri);
    umi_host_init(HOST_ID, uri);
    connected = 1'b1;
  endtask

`ifdef UMI_RX_SIM_THROTTLE_EN
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  logic [PW-1:0] poll_cnt_q, poll_cnt_d;

  always_comb begin
    poll_cnt_d = (poll_cnt_q == PW'(POLL_INTERVAL - 1)) ? '0 : poll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign poll_slot = (poll_cnt_q == '0);
`else
  localparam bit unused_poll_interval = (POLL_INTERVAL >= 1);

  assign poll_slot = 1'b1;
`endif

  // fifo_count only changes on the rising edge, so its value here is the
  // pre-pop count of the upcoming edge: a full FIFO never polls.
  assign poll_en = connected && !rst && poll_slot && (fifo_count < CW'(DEPTH));
  assign pop     = ready && !fifo_empty;

  // The host call cannot feed a same-edge write from another process without
  // a race, so it is made on the falling edge; the result is pushed on the
  // following rising edge, which is the edge the packet is received on.
  always_ff @(negedge clk) begin
    if (poll_en) begin
      host_rx_q <= umi_host_recv(HOST_ID);
    end else begin
      host_rx_q.ok <= 1'b0;
    end
  end

  umi_rx_sim_fifo #(
    .DEPTH (DEPTH),
    .W     (UMI_PACKET_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_rx_q.ok),
    .pop   (pop),
    .din   (host_rx_q.pkt),
    .dout  (packet),
    .valid (valid),
    .count (fifo_count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_umi_rx_sim.sv
module tb_umi_rx_sim;
  import umi_sim_pkg::*;

  localparam int DEPTH         = 2;
  localparam int POLL_INTERVAL = 4;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              ready = 1'b0;
  logic              valid;
  logic [255:0]      packet;

  umi_rx_sim #(
    .DEPTH         (DEPTH),
    .POLL_INTERVAL (POLL_INTERVAL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .valid  (valid),
    .packet (packet)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model: host queue and prefetch buffer as plain queues.
  umi_packet_t mdl_host[$];
  umi_packet_t mdl_fifo[$];
  int unsigned mdl_calls = 0;
  int unsigned delivered = 0;
  bit          mdl_conn  = 1'b0;
  int unsigned tcnt      = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic umi_packet_t rnd_pkt();
    umi_packet_t p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic host_push(input umi_packet_t p);
    host_q.push_back(p);
    mdl_host.push_back(p);
  endtask

  // One clock: apply the spec rules for the coming edge to the model, then
  // step the DUT and compare.
  task automatic tick();
    umi_packet_t pp   = packet;
    int          pre  = mdl_fifo.size();
    bit          slot = 1'b1;
`ifdef UMI_RX_SIM_THROTTLE_EN
    slot = (tcnt == 0);
`endif
    if (rst) begin
      mdl_fifo.delete();
      tcnt = 0;
    end else begin
      if (pre > 0 && ready) begin
        chk("order", pp, mdl_fifo[0]);
        void'(mdl_fifo.pop_front());
        delivered++;
      end
      if (mdl_conn && pre < DEPTH && slot) begin
        mdl_calls++;
        if (mdl_host.size() != 0) mdl_fifo.push_back(mdl_host.pop_front());
      end
      tcnt = (tcnt + 1) % POLL_INTERVAL;
    end
    @(posedge clk);
    #1;
    chk("valid", valid, mdl_fifo.size() != 0);
    chk("recv_calls", recv_calls, mdl_calls);
    chk("host_left", host_q.size(), mdl_host.size());
    if (mdl_fifo.size() != 0) chk("packet", packet, mdl_fifo[0]);
  endtask

  initial begin
    umi_packet_t pa;
    umi_packet_t bp[5];
    umi_packet_t pn;
    int unsigned d0;
    int unsigned c0;

    // Reset / idle, init not called.
    rst = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_valid", valid, 1'b0);
    chk("rst_packet", packet, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_no_calls", recv_calls, 0);
    chk("idle_valid", valid, 1'b0);

    // Single packet.
    dut.init("loopback");
    mdl_conn = 1'b1;
    pa = {8'hA5, 240'd0, 8'h01};
    host_push(pa);
    ready = 1'b1;
    tick();
    chk("single_valid", valid, 1'b1);
    chk("single_pkt", packet, pa);
    tick();
    chk("single_one_cycle", valid, 1'b0);

    // Backpressure and ordering.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp[i] = rnd_pkt();
      host_push(bp[i]);
    end
    for (int i = 0; i < 10; i++) tick();
    chk("bp_host_left", host_q.size(), 3);
    chk("bp_hold", packet, bp[0]);
    d0 = delivered;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_delivered", delivered - d0, 5);

    // Full FIFO with simultaneous pop: no poll that edge, resumes next.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) host_push(rnd_pkt());
    for (int i = 0; i < 4; i++) tick();
    c0 = recv_calls;
    ready = 1'b1;
    tick();
    chk("full_no_poll", recv_calls, c0);
    chk("full_host_kept", host_q.size(), 1);
    ready = 1'b0;
    tick();
    chk("full_poll_resume", host_q.size(), 0);
    chk("full_refilled", valid, 1'b1);

    // Reset mid-stream: buffered packets dropped, no re-init needed.
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_packet", packet, '0);
    rst = 1'b0;
    pn = rnd_pkt();
    host_push(pn);
    ready = 1'b1;
    tick();
    chk("post_rst_valid", valid, 1'b1);
    chk("post_rst_pkt", packet, pn);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) host_push(rnd_pkt());
      tick();
    end
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    chk("drained_host", host_q.size(), 0);
    chk("drained_valid", valid, 1'b0);

`ifdef UMI_RX_SIM_THROTTLE_EN
    begin
      int  last;
      bit  prev;
      last = -1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) host_push(rnd_pkt());
      prev = valid;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (valid && !prev) begin
          if (last >= 0) chk("thr_gap", c - last, POLL_INTERVAL);
          last = c;
        end
        prev = valid;
      end
      chk("thr_host_empty", host_q.size(), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
